// File: rtl/control_sequencer_pkg.sv
// Shared SAP-1 definitions: opcodes, one-hot T-state constants and the
// control-word bit layout used by both the sequencer and the datapath top.
package sap1_pkg;

   localparam int SAP_OP_W  = 4;
   localparam int SAP_T_LEN = 6;

   localparam logic [SAP_OP_W-1:0] OP_LDA = 4'b0000;
   localparam logic [SAP_OP_W-1:0] OP_ADD = 4'b0001;
   localparam logic [SAP_OP_W-1:0] OP_SUB = 4'b0010;
   localparam logic [SAP_OP_W-1:0] OP_OUT = 4'b1110;
   localparam logic [SAP_OP_W-1:0] OP_HLT = 4'b1111;

   localparam logic [SAP_T_LEN-1:0] T1 = 6'b000001;
   localparam logic [SAP_T_LEN-1:0] T2 = 6'b000010;
   localparam logic [SAP_T_LEN-1:0] T3 = 6'b000100;
   localparam logic [SAP_T_LEN-1:0] T4 = 6'b001000;
   localparam logic [SAP_T_LEN-1:0] T5 = 6'b010000;
   localparam logic [SAP_T_LEN-1:0] T6 = 6'b100000;

   // Control-word bit positions; the datapath top indexes the same word.
   localparam int CW_PC_INC   = 0;
   localparam int CW_PC_SEND  = 1;
   localparam int CW_MAR_LOAD = 2;
   localparam int CW_RAM_SEND = 3;
   localparam int CW_IR_LOAD  = 4;
   localparam int CW_IR_SEND  = 5;
   localparam int CW_ACC_LOAD = 6;
   localparam int CW_ACC_SEND = 7;
   localparam int CW_ALU_SUB  = 8;
   localparam int CW_ALU_SEND = 9;
   localparam int CW_B_LOAD   = 10;
   localparam int CW_OUT_LOAD = 11;
   localparam int CW_W        = 12;

   typedef logic [CW_W-1:0] ctrl_word_t;

   typedef enum logic {
      SEQ_RUN  = 1'b0,
      SEQ_HALT = 1'b1
   } seq_state_t;

   function automatic ctrl_word_t cw_bit(input int idx);
      return ctrl_word_t'(1) << idx;
   endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Opcode input and control strobes between the SAP-1 sequencer and the datapath.
interface control_sequencer_if #(
   parameter int OP_W  = 4,
   parameter int T_LEN = 6
);
   logic [OP_W-1:0]  i_opcode;
   logic [T_LEN-1:0] o_tstate;
   logic             o_pc_inc;
   logic             o_pc_send;
   logic             o_mar_load;
   logic             o_ram_send;
   logic             o_ir_load;
   logic             o_ir_send;
   logic             o_acc_load;
   logic             o_acc_send;
   logic             o_alu_sub;
   logic             o_alu_send;
   logic             o_b_load;
   logic             o_out_load;
   logic             o_halted;

   modport master (
      output i_opcode,
      input  o_tstate, o_pc_inc, o_pc_send, o_mar_load, o_ram_send, o_ir_load,
             o_ir_send, o_acc_load, o_acc_send, o_alu_sub, o_alu_send,
             o_b_load, o_out_load, o_halted
   );

   modport slave (
      input  i_opcode,
      output o_tstate, o_pc_inc, o_pc_send, o_mar_load, o_ram_send, o_ir_load,
             o_ir_send, o_acc_load, o_acc_send, o_alu_sub, o_alu_send,
             o_b_load, o_out_load, o_halted
   );
endinterface

// File: rtl/control_sequencer_ring_counter.sv
// One-hot T-state ring counter: resets to T1, rotates one step per clock
// unless hold is asserted.
module ring_counter #(
   parameter int T_LEN = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             hold,
   output logic [T_LEN-1:0] tstate
);

   logic [T_LEN-1:0] ring_d;
   logic [T_LEN-1:0] ring_q;

   genvar gi;
   generate
      for (gi = 0; gi < T_LEN; gi++) begin : g_rot
         assign ring_d[gi] = hold ? ring_q[gi] : ring_q[(gi + T_LEN - 1) % T_LEN];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         ring_q <= T_LEN'(1);
      end else begin
         ring_q <= ring_d;
      end
   end

   assign tstate = ring_q;

endmodule

// File: rtl/control_sequencer.sv
// SAP-1 controller-sequencer: HALT flag plus the Moore decoder that turns the
// current T-state and IR opcode into datapath load/send strobes.
module control_sequencer
   import sap1_pkg::*;
#(
   parameter int OP_W  = SAP_OP_W,
   parameter int T_LEN = SAP_T_LEN
) (
   input  logic                clk,
   input  logic                reset,
   control_sequencer_if.slave  ctl
);

   seq_state_t       state_d;
   seq_state_t       state_q;
   logic [T_LEN-1:0] ring_tstate;
   logic [OP_W-1:0]  opcode;
   logic             hlt_now;
   logic             hold;
   ctrl_word_t       cw;

   assign opcode = ctl.i_opcode;

   // HLT is recognised in T4; holding the ring on that same edge freezes it at T4.
   assign hlt_now = (state_q == SEQ_RUN) && (ring_tstate == T4) && (opcode == OP_HLT);
   assign hold    = (state_q == SEQ_HALT) || hlt_now;

   ring_counter #(
      .T_LEN (T_LEN)
   ) u_ring (
      .clk    (clk),
      .reset  (reset),
      .hold   (hold),
      .tstate (ring_tstate)
   );

   always_comb begin
      state_d = state_q;
      if (hlt_now) begin
         state_d = SEQ_HALT;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= SEQ_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      cw = '0;
      if (!reset && state_q == SEQ_RUN) begin
         case (ring_tstate)
            T1: cw = cw_bit(CW_PC_SEND) | cw_bit(CW_MAR_LOAD);
            T2: cw = cw_bit(CW_PC_INC);
            T3: cw = cw_bit(CW_RAM_SEND) | cw_bit(CW_IR_LOAD);
            T4: begin
               case (opcode)
                  OP_LDA, OP_ADD, OP_SUB: cw = cw_bit(CW_IR_SEND) | cw_bit(CW_MAR_LOAD);
                  OP_OUT:                 cw = cw_bit(CW_ACC_SEND) | cw_bit(CW_OUT_LOAD);
                  default:                cw = '0;
               endcase
            end
            T5: begin
               case (opcode)
                  OP_LDA:  cw = cw_bit(CW_RAM_SEND) | cw_bit(CW_ACC_LOAD);
                  OP_ADD:  cw = cw_bit(CW_RAM_SEND) | cw_bit(CW_B_LOAD);
                  OP_SUB:  cw = cw_bit(CW_RAM_SEND) | cw_bit(CW_B_LOAD) | cw_bit(CW_ALU_SUB);
                  default: cw = '0;
               endcase
            end
            T6: begin
               case (opcode)
                  OP_ADD:  cw = cw_bit(CW_ALU_SEND) | cw_bit(CW_ACC_LOAD);
                  OP_SUB:  cw = cw_bit(CW_ALU_SEND) | cw_bit(CW_ACC_LOAD) | cw_bit(CW_ALU_SUB);
                  default: cw = '0;
               endcase
            end
            default: cw = '0;
         endcase
      end
   end

   assign ctl.o_tstate   = reset ? T_LEN'(1) : ring_tstate;
   assign ctl.o_halted   = (state_q == SEQ_HALT);
   assign ctl.o_pc_inc   = cw[CW_PC_INC];
   assign ctl.o_pc_send  = cw[CW_PC_SEND];
   assign ctl.o_mar_load = cw[CW_MAR_LOAD];
   assign ctl.o_ram_send = cw[CW_RAM_SEND];
   assign ctl.o_ir_load  = cw[CW_IR_LOAD];
   assign ctl.o_ir_send  = cw[CW_IR_SEND];
   assign ctl.o_acc_load = cw[CW_ACC_LOAD];
   assign ctl.o_acc_send = cw[CW_ACC_SEND];
   assign ctl.o_alu_sub  = cw[CW_ALU_SUB];
   assign ctl.o_alu_send = cw[CW_ALU_SEND];
   assign ctl.o_b_load   = cw[CW_B_LOAD];
   assign ctl.o_out_load = cw[CW_OUT_LOAD];

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: the driver queues hand-written
// per-cycle expectations, the negedge monitor pops and compares them.
module tb_control_sequencer;

   localparam logic [11:0] S_NONE     = 12'h000;
   localparam logic [11:0] S_PC_INC   = 12'h800;
   localparam logic [11:0] S_PC_SEND  = 12'h400;
   localparam logic [11:0] S_MAR_LOAD = 12'h200;
   localparam logic [11:0] S_RAM_SEND = 12'h100;
   localparam logic [11:0] S_IR_LOAD  = 12'h080;
   localparam logic [11:0] S_IR_SEND  = 12'h040;
   localparam logic [11:0] S_ACC_LOAD = 12'h020;
   localparam logic [11:0] S_ACC_SEND = 12'h010;
   localparam logic [11:0] S_ALU_SUB  = 12'h008;
   localparam logic [11:0] S_ALU_SEND = 12'h004;
   localparam logic [11:0] S_B_LOAD   = 12'h002;
   localparam logic [11:0] S_OUT_LOAD = 12'h001;

   localparam logic [5:0] TS1 = 6'b000001;
   localparam logic [5:0] TS2 = 6'b000010;
   localparam logic [5:0] TS3 = 6'b000100;
   localparam logic [5:0] TS4 = 6'b001000;
   localparam logic [5:0] TS5 = 6'b010000;
   localparam logic [5:0] TS6 = 6'b100000;

   // Halted expectation: 0, 1, or 2 meaning "not checked this cycle".
   localparam logic [1:0] H0 = 2'd0;
   localparam logic [1:0] H1 = 2'd1;
   localparam logic [1:0] HX = 2'd2;

   typedef struct {
      logic [5:0]  t;
      logic [11:0] s;
      logic [1:0]  h;
      int          id;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   control_sequencer_if bus ();

   control_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .ctl   (bus)
   );

   exp_t        exp_q[$];
   int          n_cmp  = 0;
   int          n_bad  = 0;
   int          step_id = 0;
   logic [11:0] act_s;
   logic [4:0]  act_sends;

   assign act_s = {bus.o_pc_inc, bus.o_pc_send, bus.o_mar_load, bus.o_ram_send,
                   bus.o_ir_load, bus.o_ir_send, bus.o_acc_load, bus.o_acc_send,
                   bus.o_alu_sub, bus.o_alu_send, bus.o_b_load, bus.o_out_load};
   assign act_sends = {bus.o_pc_send, bus.o_ram_send, bus.o_ir_send,
                       bus.o_acc_send, bus.o_alu_send};

   task automatic step(input logic r, input logic [3:0] op, input logic [5:0] t,
                       input logic [11:0] s, input logic [1:0] h);
      exp_t e;
      reset        = r;
      bus.i_opcode = op;
      e.t  = t;
      e.s  = s;
      e.h  = h;
      e.id = step_id;
      exp_q.push_back(e);
      step_id++;
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [3:0] op);
      step(1'b0, op, TS1, S_PC_SEND | S_MAR_LOAD, H0);
      step(1'b0, op, TS2, S_PC_INC, H0);
      step(1'b0, op, TS3, S_RAM_SEND | S_IR_LOAD, H0);
   endtask

   task automatic lda_exec();
      step(1'b0, 4'b0000, TS4, S_IR_SEND | S_MAR_LOAD, H0);
      step(1'b0, 4'b0000, TS5, S_RAM_SEND | S_ACC_LOAD, H0);
      step(1'b0, 4'b0000, TS6, S_NONE, H0);
   endtask

   task automatic add_exec();
      step(1'b0, 4'b0001, TS4, S_IR_SEND | S_MAR_LOAD, H0);
      step(1'b0, 4'b0001, TS5, S_RAM_SEND | S_B_LOAD, H0);
      step(1'b0, 4'b0001, TS6, S_ALU_SEND | S_ACC_LOAD, H0);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      n_cmp++;
      if ($countones(act_sends) > 1) begin
         n_bad++;
         $display("FAIL one_send cyc=%0d sends=%b required at most one high", step_id, act_sends);
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (bus.o_tstate !== e.t) begin
            n_bad++;
            $display("FAIL tstate cyc=%0d got %b want %b", e.id, bus.o_tstate, e.t);
         end
         n_cmp++;
         if (act_s !== e.s) begin
            n_bad++;
            $display("FAIL strobes cyc=%0d got %b want %b", e.id, act_s, e.s);
         end
         if (e.h != HX) begin
            n_cmp++;
            if (bus.o_halted !== e.h[0]) begin
               n_bad++;
               $display("FAIL halted cyc=%0d got %b want %b", e.id, bus.o_halted, e.h[0]);
            end
         end
         $display("cyc %0d rst=%b op=%b t=%b strobes=%b halted=%b", e.id, reset,
                  bus.i_opcode, bus.o_tstate, act_s, bus.o_halted);
      end
   end

   initial begin
      reset        = 1'b1;
      bus.i_opcode = 4'b0000;
      @(posedge clk);
      #1;

      // Reset: T1 shown, strobes forced off.
      step(1'b1, 4'b0000, TS1, S_NONE, HX);
      step(1'b1, 4'b0000, TS1, S_NONE, H0);

      // LDA twice, proving T6 wraps back to T1.
      for (int k = 0; k < 2; k++) begin
         fetch(4'b0000);
         lda_exec();
      end

      // ADD, with HLT on the opcode lines during fetch (must be ignored there).
      fetch(4'b1111);
      add_exec();

      // SUB.
      fetch(4'b0010);
      step(1'b0, 4'b0010, TS4, S_IR_SEND | S_MAR_LOAD, H0);
      step(1'b0, 4'b0010, TS5, S_RAM_SEND | S_B_LOAD | S_ALU_SUB, H0);
      step(1'b0, 4'b0010, TS6, S_ALU_SEND | S_ACC_LOAD | S_ALU_SUB, H0);

      // OUT.
      fetch(4'b1110);
      step(1'b0, 4'b1110, TS4, S_ACC_SEND | S_OUT_LOAD, H0);
      step(1'b0, 4'b1110, TS5, S_NONE, H0);
      step(1'b0, 4'b1110, TS6, S_NONE, H0);

      // Undefined opcode behaves as NOP, then a normal LDA follows.
      fetch(4'b0101);
      step(1'b0, 4'b0101, TS4, S_NONE, H0);
      step(1'b0, 4'b0101, TS5, S_NONE, H0);
      step(1'b0, 4'b0101, TS6, S_NONE, H0);
      fetch(4'b0000);
      lda_exec();

      // ADD aborted by reset in T5: no b_load, restart at T1.
      fetch(4'b0001);
      step(1'b0, 4'b0001, TS4, S_IR_SEND | S_MAR_LOAD, H0);
      step(1'b1, 4'b0001, TS1, S_NONE, H0);
      fetch(4'b0001);
      add_exec();

      // HLT: T4 with no strobes, then frozen at T4 regardless of opcode.
      fetch(4'b0000);
      step(1'b0, 4'b1111, TS4, S_NONE, H0);
      for (int k = 0; k < 22; k++) begin
         step(1'b0, 4'(k), TS4, S_NONE, H1);
      end

      // One reset clock leaves HALT and restarts at T1.
      step(1'b1, 4'b1111, TS1, S_NONE, HX);
      fetch(4'b0000);
      lda_exec();

      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain got %0d pending want 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
